// File: rtl/elevator_call_scheduler_if.sv
// Call/target bundle between the call inputs, the scheduler and the car movement FSM.
// The master side is the scheduler; the slave side is the call panel plus car FSM.
interface elevator_call_scheduler_if;
   logic       tick;
   logic [3:0] call_req;
   logic [3:0] car_floor;
   logic [3:0] target_floor;
   logic [3:0] pending;
   logic       door_open;
   logic       moving;
   logic       dir_up;
   logic       fault;

   modport master (
      input  tick, call_req, car_floor,
      output target_floor, pending, door_open, moving, dir_up, fault
   );

   modport slave (
      output tick, call_req, car_floor,
      input  target_floor, pending, door_open, moving, dir_up, fault
   );
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a 4-floor car: latches calls, issues one-hot targets, sequences door dwell.
// Latency: calls visible 1 clk after sampling, decisions 1 clk later; no backpressure, calls are level-sampled.
module elevator_call_scheduler #(
   parameter int unsigned DOOR_TICKS = 2
) (
   input logic                        clk,
   input logic                        reset,
   elevator_call_scheduler_if.master  bus
);
   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   localparam logic [3:0] DWELL_LAST = 4'(DOOR_TICKS);

   state_t     state_q, state_d;
   logic [3:0] target_q, target_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] cnt_q, cnt_d;
   logic       dir_q, dir_d;
   logic       fault_q, fault_d;
   logic [3:0] clr;

   logic       car_ok;
   logic [3:0] below_mask, above, below;
   logic [3:0] lo_above, hi_below;
   logic [3:0] sel;
   logic       sel_dir, sel_vld;

   // One-hot check without $onehot so the expression stays portable across synth tools.
   assign car_ok     = (bus.car_floor != 4'b0000) &&
                       ((bus.car_floor & (bus.car_floor - 4'd1)) == 4'b0000);
   assign below_mask = bus.car_floor - 4'd1;
   assign below      = pending_q & below_mask;
   assign above      = pending_q & ~(below_mask | bus.car_floor);

   always_comb begin
      lo_above = 4'b0000;
      hi_below = 4'b0000;
      for (int i = 3; i >= 0; i--) begin
         if (above[i]) lo_above = 4'b0001 << i;
      end
      for (int i = 0; i < 4; i++) begin
         if (below[i]) hi_below = 4'b0001 << i;
      end
   end

   // Keep sweeping the current way while anything lies ahead; otherwise reverse.
   always_comb begin
      sel     = 4'b0000;
      sel_dir = dir_q;
      sel_vld = 1'b0;
      if (dir_q) begin
         if (above != 4'b0000) begin
            sel = lo_above; sel_dir = 1'b1; sel_vld = 1'b1;
         end else if (below != 4'b0000) begin
            sel = hi_below; sel_dir = 1'b0; sel_vld = 1'b1;
         end
      end else begin
         if (below != 4'b0000) begin
            sel = hi_below; sel_dir = 1'b0; sel_vld = 1'b1;
         end else if (above != 4'b0000) begin
            sel = lo_above; sel_dir = 1'b1; sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      fault_d  = fault_q;
      clr      = 4'b0000;
      // An invalid floor code freezes scheduling; calls still latch but nothing clears.
      if (!car_ok) begin
         fault_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if ((pending_q & bus.car_floor) != 4'b0000) begin
                  state_d  = DOOR;
                  target_d = bus.car_floor;
                  cnt_d    = 4'd0;
                  clr      = bus.car_floor;
               end else if (sel_vld) begin
                  state_d  = MOVE;
                  target_d = sel;
                  dir_d    = sel_dir;
               end else begin
                  target_d = bus.car_floor;
               end
            end
            MOVE: begin
               if (bus.car_floor == target_q) begin
                  state_d  = DOOR;
                  target_d = bus.car_floor;
                  cnt_d    = 4'd0;
                  clr      = bus.car_floor;
               end else if (sel_vld) begin
                  target_d = sel;
                  dir_d    = sel_dir;
               end
            end
            DOOR: begin
               target_d = bus.car_floor;
               clr      = bus.car_floor;
               if (bus.tick) begin
                  if (cnt_q + 4'd1 == DWELL_LAST) begin
                     state_d = IDLE;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      pending_d = (pending_q | bus.call_req) & ~clr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         target_q  <= 4'b0001;
         pending_q <= 4'b0000;
         cnt_q     <= 4'd0;
         dir_q     <= 1'b1;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         fault_q   <= fault_d;
      end
   end

   assign bus.target_floor = target_q;
   assign bus.pending      = pending_q;
   assign bus.door_open    = (state_q == DOOR);
   assign bus.moving       = (state_q == MOVE);
   assign bus.dir_up       = dir_q;
   assign bus.fault        = fault_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed scenarios for the call scheduler with hand-computed expectations (DOOR_TICKS = 2).
module tb_elevator_call_scheduler;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   elevator_call_scheduler_if bus ();

   elevator_call_scheduler #(.DOOR_TICKS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_pulse();
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
   endtask

   task automatic call_pulse(input logic [3:0] c);
      bus.call_req = c;
      step(1);
      bus.call_req = 4'b0000;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset        = 1'b1;
      bus.tick     = 1'b0;
      bus.call_req = 4'b0000;
      bus.car_floor = 4'b0001;
      step(2);
      check("rst_target",  bus.target_floor,   4'b0001);
      check("rst_pending", bus.pending,        4'b0000);
      check("rst_door",    4'(bus.door_open),  4'd0);
      check("rst_moving",  4'(bus.moving),     4'd0);
      check("rst_dir",     4'(bus.dir_up),     4'd1);
      check("rst_fault",   4'(bus.fault),      4'd0);
      reset = 1'b0;
      step(1);

      // Basic up move with a call for the open-door floor mid-dwell
      call_pulse(4'b0100);
      check("up_pending",  bus.pending,        4'b0100);
      check("up_nomove",   4'(bus.moving),     4'd0);
      step(1);
      check("up_target",   bus.target_floor,   4'b0100);
      check("up_moving",   4'(bus.moving),     4'd1);
      check("up_dir",      4'(bus.dir_up),     4'd1);
      bus.car_floor = 4'b0010;
      step(1);
      check("up_via",      bus.target_floor,   4'b0100);
      bus.car_floor = 4'b0100;
      step(1);
      check("up_door",     4'(bus.door_open),  4'd1);
      check("up_stopped",  4'(bus.moving),     4'd0);
      check("up_clr",      bus.pending,        4'b0000);
      tick_pulse();
      check("dwell_t1",    4'(bus.door_open),  4'd1);
      call_pulse(4'b0100);
      check("absorb_pend", bus.pending,        4'b0000);
      check("absorb_door", 4'(bus.door_open),  4'd1);
      tick_pulse();
      check("dwell_end",   4'(bus.door_open),  4'd0);
      check("dwell_pend",  bus.pending,        4'b0000);

      // SCAN: calls on both sides, up sweep served first
      bus.car_floor = 4'b0010;
      step(1);
      call_pulse(4'b1001);
      check("scan_pend",   bus.pending,        4'b1001);
      step(1);
      check("scan_tgt1",   bus.target_floor,   4'b1000);
      check("scan_dir1",   4'(bus.dir_up),     4'd1);
      bus.car_floor = 4'b0100;
      step(1);
      bus.car_floor = 4'b1000;
      step(1);
      check("scan_door1",  4'(bus.door_open),  4'd1);
      check("scan_left",   bus.pending,        4'b0001);
      tick_pulse();
      tick_pulse();
      check("scan_close",  4'(bus.door_open),  4'd0);
      step(1);
      check("scan_tgt2",   bus.target_floor,   4'b0001);
      check("scan_dir2",   4'(bus.dir_up),     4'd0);
      check("scan_mv2",    4'(bus.moving),     4'd1);
      bus.car_floor = 4'b0100;
      step(1);
      bus.car_floor = 4'b0010;
      step(1);
      bus.car_floor = 4'b0001;
      step(1);
      check("scan_door2",  4'(bus.door_open),  4'd1);
      tick_pulse();
      tick_pulse();

      // Long up move with a fault and an intermediate stop
      call_pulse(4'b1000);
      step(1);
      check("int_tgt",     bus.target_floor,   4'b1000);
      check("int_dir",     4'(bus.dir_up),     4'd1);
      bus.car_floor = 4'b0010;
      step(1);
      bus.car_floor = 4'b0110;
      step(1);
      check("flt_set",     4'(bus.fault),      4'd1);
      check("flt_tgt",     bus.target_floor,   4'b1000);
      step(1);
      check("flt_hold",    4'(bus.moving),     4'd1);
      bus.car_floor = 4'b0010;
      step(1);
      check("flt_sticky",  4'(bus.fault),      4'd1);
      check("flt_resume",  4'(bus.moving),     4'd1);
      call_pulse(4'b0100);
      check("int_pend",    bus.pending,        4'b1100);
      step(1);
      check("int_switch",  bus.target_floor,   4'b0100);
      bus.car_floor = 4'b0100;
      step(1);
      check("int_door",    4'(bus.door_open),  4'd1);
      check("int_left",    bus.pending,        4'b1000);
      tick_pulse();
      call_pulse(4'b0001);
      check("int_both",    bus.pending,        4'b1001);
      tick_pulse();
      check("int_close",   4'(bus.door_open),  4'd0);
      step(1);
      check("int_resume",  bus.target_floor,   4'b1000);
      check("int_keepup",  4'(bus.dir_up),     4'd1);

      // Asynchronous reset during a dwell
      bus.car_floor = 4'b1000;
      step(1);
      check("rmo_door",    4'(bus.door_open),  4'd1);
      call_pulse(4'b0010);
      check("rmo_pend",    bus.pending,        4'b0011);
      #2 reset = 1'b1;
      #1;
      check("rmo_pending", bus.pending,        4'b0000);
      check("rmo_door0",   4'(bus.door_open),  4'd0);
      check("rmo_target",  bus.target_floor,   4'b0001);
      check("rmo_dir",     4'(bus.dir_up),     4'd1);
      check("rmo_fault",   4'(bus.fault),      4'd0);
      step(1);
      reset = 1'b0;
      step(1);
      check("post_idle",   bus.target_floor,   4'b1000);
      check("post_moving", 4'(bus.moving),     4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
